reg_file_wr_arb: RTL and testbench
==================================

# reg_file_wr_arb

Integer register file with an arbitrated multi-source write side. Holds the 32 architectural registers read by the core. Accepts one unconditional write per cycle from the core pipeline, plus posted writes from multi-cycle execution units (integer divider, and later units) over the `rf_wr_req`/`rf_wr_ack` handshake. This block is the responder end of that handshake: it decides which unit's write commits each cycle and returns the acknowledge.

## Interface

Parameters:
- `data_width`, 32, register width
- `reg_sel_width`, 5, register index width (2^reg_sel_width registers)
- `num_units`, 2, number of handshake write sources

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `rd_sel_a`  in  reg_sel_width  read port A index
- `rd_data_a`  out  data_width  read port A data, combinational
- `rd_sel_b`  in  reg_sel_width  read port B index
- `rd_data_b`  out  data_width  read port B data, combinational
- `core_wr_req`  in  1  core write this cycle; no handshake
- `core_wr_sel`  in  reg_sel_width  core write index
- `core_wr_data`  in  data_width  core write data
- `rf_wr_req`  in  num_units  per-unit write request
- `rf_wr_sel`  in  num_units*reg_sel_width  packed; unit i at bits [i*reg_sel_width +: reg_sel_width]
- `rf_wr_data`  in  num_units*data_width  packed; unit i at bits [i*data_width +: data_width]
- `rf_wr_ack`  out  num_units  per-unit acknowledge, one-hot or zero

## Operation

- Storage:
  - Registers 1..2^reg_sel_width-1 are flops.
  - Index 0 always reads 0.
  - Writes to index 0 complete normally (acked if from a unit) but store nothing.
- Reads:
  - `rd_data_x` = committed register contents.
  - No write-through: a write committing at the same edge is visible only from the next cycle.
- Handshake rules, per unit:
  - The unit raises `rf_wr_req[i]` with sel/data and holds all three stable until it samples `rf_wr_ack[i]` high at a rising edge.
  - That edge commits the write.
  - After that edge the unit may drop req, or present the next write (e.g. divider quotient then remainder) in the following cycle.
  - Units must not derive `rf_wr_req` combinationally from `rf_wr_ack`.
- Arbitration, each cycle:
  - If `core_wr_req` is high: the core write commits and all `rf_wr_ack` are 0.
  - Else, if any unit req is high: exactly one unit is granted, by round-robin starting at pointer `rr_ptr`. The lowest index ≥ `rr_ptr` (wrapping) with req high wins.
  - `rf_wr_ack[grant]` = 1 combinationally in that cycle; the write commits at the ending edge.
  - After a grant, `rr_ptr` ← grant+1 mod num_units. With no grant, `rr_ptr` holds.
- Arbiter states:
  - IDLE: no req.
  - CORE: core_wr_req high.
  - GRANT(i).
  - The state is combinational per cycle; the only persistent arbitration state is `rr_ptr`.
- Reset (rst low, asynchronous):
  - All registers ← 0, `rr_ptr` ← 0.
  - `rf_wr_ack` forced to 0 while rst is low.
  - A handshake in flight when reset asserts is dropped without commit.
  - The unit is reset by the same signal.

## Timing

- Write latency: data is visible on a read port in the cycle after the commit edge.
- Ack is zero-latency: it is asserted in the same cycle as an eligible req, unless the core or another unit wins.
- Maximum wait for a unit with req held: (num_units-1) unit grants plus any core-write cycles. Core writes may starve units; this is accepted, since the core writes at most once per instruction.
- Simultaneous events:
  - Core and unit target the same index: the core commits and the unit waits.
  - A unit write commits at a later edge and overwrites the core value, in grant order.
- `rf_wr_ack` is never high for a unit whose req is low.
- Only one write commits per edge.

## Test plan

- **Reset:**
  - Drive rst low mid-cycle with `rf_wr_req[0]` high → `rf_wr_ack` = 0 immediately.
  - After release, all reads return 0 and `rr_ptr` = 0.
- **Divider-style pair on unit 0:**
  - Stimulus: req held with sel=3, data=81; core idle.
  - Expected: ack high in the first cycle; sel=3, data=81 committed at that edge.
  - Stimulus: unit then presents sel=7, data=37.
  - Expected: ack again and commit; following cycle `rd_data_a`(sel 3) = 81 and `rd_data_b`(sel 7) = 37.
- **Core priority:**
  - Stimulus: core writes sel=5, data=11 for 3 cycles while unit 0 requests sel=5, data=99.
  - Expected: ack 0 for 3 cycles, then ack in cycle 4; final reg5 = 99.
- **Round-robin:**
  - Stimulus: units 0 and 1 request continuously with distinct writes; each unit advances to its next write after ack.
  - Expected: acks alternate 0,1,0,1.
  - Stimulus: only unit 1 requests.
  - Expected: unit 1 is granted back-to-back.
- **x0:**
  - Stimulus: unit 1 writes sel=0, data=0xFFFFFFFF.
  - Expected: ack asserted; `rd_data` at sel 0 reads 0 afterwards.
- **Read timing:**
  - Stimulus: core writes sel=2, data=42 while `rd_sel_a`=2.
  - Expected: old value 0 during the write cycle; 42 the next cycle.

Source files
------------

// File: rtl/reg_file_wr_arb.sv
// Integer register file: one unhandshaked core write port plus round-robin arbitrated unit write ports.
// Reads are combinational with no write-through; unit acks are zero-latency, and the core always wins.
module reg_file_wr_arb #(
    parameter int data_width    = 32,
    parameter int reg_sel_width = 5,
    parameter int num_units     = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [reg_sel_width-1:0]           rd_sel_a,
    output logic [data_width-1:0]              rd_data_a,
    input  logic [reg_sel_width-1:0]           rd_sel_b,
    output logic [data_width-1:0]              rd_data_b,
    input  logic                               core_wr_req,
    input  logic [reg_sel_width-1:0]           core_wr_sel,
    input  logic [data_width-1:0]              core_wr_data,
    input  logic [num_units-1:0]               rf_wr_req,
    input  logic [num_units*reg_sel_width-1:0] rf_wr_sel,
    input  logic [num_units*data_width-1:0]    rf_wr_data,
    output logic [num_units-1:0]               rf_wr_ack
);
    localparam int num_regs  = 1 << reg_sel_width;
    localparam int ptr_width = (num_units > 1) ? $clog2(num_units) : 1;
    localparam logic [ptr_width-1:0] last_unit = ptr_width'(num_units - 1);

    typedef enum logic [1:0] {ARB_IDLE, ARB_CORE, ARB_GRANT} arb_state_e;

    arb_state_e              arb_state;
    logic [ptr_width-1:0]    rr_ptr_q;
    logic [ptr_width-1:0]    rr_ptr_d;
    logic [ptr_width-1:0]    grant_idx;
    logic                    grant_vld;
    logic [data_width-1:0]   regs_q [num_regs];
    logic                    wr_en;
    logic [reg_sel_width-1:0] wr_sel;
    logic [data_width-1:0]   wr_data;

    // Lowest requesting unit at or after rr_ptr, wrapping around.
    always_comb begin
        int                   idx;
        logic [ptr_width-1:0] cand;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        cand      = '0;
        for (int k = 0; k < num_units; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= num_units) begin
                idx = idx - num_units;
            end
            cand = ptr_width'(idx);
            if (!grant_vld && rf_wr_req[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        arb_state = ARB_IDLE;
        if (core_wr_req) begin
            arb_state = ARB_CORE;
        end else if (grant_vld) begin
            arb_state = ARB_GRANT;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (arb_state == ARB_GRANT) begin
            rr_ptr_d = (grant_idx == last_unit) ? '0 : grant_idx + ptr_width'(1);
        end
    end

    // Ack is masked by rst so an in-flight handshake is dropped the instant reset asserts.
    always_comb begin
        rf_wr_ack = '0;
        wr_en     = 1'b0;
        wr_sel    = core_wr_sel;
        wr_data   = core_wr_data;
        case (arb_state)
            ARB_CORE: begin
                wr_en = 1'b1;
            end
            ARB_GRANT: begin
                rf_wr_ack[grant_idx] = rst;
                wr_en   = 1'b1;
                wr_sel  = rf_wr_sel[int'(grant_idx)*reg_sel_width +: reg_sel_width];
                wr_data = rf_wr_data[int'(grant_idx)*data_width +: data_width];
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q <= '0;
            for (int r = 0; r < num_regs; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            if (wr_en && (wr_sel != '0)) begin
                regs_q[wr_sel] <= wr_data;
            end
        end
    end

    assign rd_data_a = (rd_sel_a == '0) ? '0 : regs_q[rd_sel_a];
    assign rd_data_b = (rd_sel_b == '0) ? '0 : regs_q[rd_sel_b];

endmodule

// File: tb/tb_reg_file_wr_arb.sv
// Scoreboard bench for reg_file_wr_arb: directed scenarios then randomized traffic against a
// behavioural model of register contents and round-robin grant order.
module tb_reg_file_wr_arb;
    localparam int DW = 32;
    localparam int SW = 5;
    localparam int NU = 2;
    localparam int NR = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [SW-1:0]    rd_sel_a, rd_sel_b;
    logic [DW-1:0]    rd_data_a, rd_data_b;
    logic             core_wr_req;
    logic [SW-1:0]    core_wr_sel;
    logic [DW-1:0]    core_wr_data;
    logic [NU-1:0]    rf_wr_req;
    logic [NU*SW-1:0] rf_wr_sel;
    logic [NU*DW-1:0] rf_wr_data;
    logic [NU-1:0]    rf_wr_ack;

    reg_file_wr_arb #(.data_width(DW), .reg_sel_width(SW), .num_units(NU)) dut (
        .clk(clk), .rst(rst),
        .rd_sel_a(rd_sel_a), .rd_data_a(rd_data_a),
        .rd_sel_b(rd_sel_b), .rd_data_b(rd_data_b),
        .core_wr_req(core_wr_req), .core_wr_sel(core_wr_sel), .core_wr_data(core_wr_data),
        .rf_wr_req(rf_wr_req), .rf_wr_sel(rf_wr_sel), .rf_wr_data(rf_wr_data),
        .rf_wr_ack(rf_wr_ack)
    );

    typedef struct { logic [SW-1:0] sel; logic [DW-1:0] data; } wr_t;
    typedef struct { logic [NU-1:0] ack; logic [DW-1:0] a; logic [DW-1:0] b; } exp_t;

    wr_t     uq0[$];
    wr_t     uq1[$];
    exp_t    exp_q[$];
    logic [DW-1:0] model_rf [NR];
    int      model_ptr;       // unit that has first claim on the next grant
    int      checks = 0;
    int      errors = 0;

    logic          c_req;
    logic [SW-1:0] c_sel;
    logic [DW-1:0] c_data;
    logic [SW-1:0] r_a, r_b;

    task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_wr(int u, int sel, logic [DW-1:0] data);
        wr_t w;
        w.sel  = SW'(sel);
        w.data = data;
        if (u == 0) uq0.push_back(w);
        else        uq1.push_back(w);
    endtask

    task automatic model_clear();
        uq0.delete();
        uq1.delete();
        for (int i = 0; i < NR; i++) model_rf[i] = '0;
        model_ptr = 0;
        c_req = 1'b0;
    endtask

    // One clock cycle of stimulus; expectation for that cycle goes to the scoreboard,
    // then the model commits whatever the rules say lands at the closing edge.
    task automatic step();
        exp_t          e;
        wr_t           w;
        logic [NU-1:0] req;
        int            g;
        @(negedge clk);
        req = {NU{1'b0}};
        req[0] = (uq0.size() != 0);
        req[1] = (uq1.size() != 0);
        rf_wr_req = req;
        if (req[0]) begin
            rf_wr_sel[0 +: SW]  = uq0[0].sel;
            rf_wr_data[0 +: DW] = uq0[0].data;
        end else begin
            rf_wr_sel[0 +: SW]  = SW'($urandom);
            rf_wr_data[0 +: DW] = $urandom;
        end
        if (req[1]) begin
            rf_wr_sel[SW +: SW]  = uq1[0].sel;
            rf_wr_data[DW +: DW] = uq1[0].data;
        end else begin
            rf_wr_sel[SW +: SW]  = SW'($urandom);
            rf_wr_data[DW +: DW] = $urandom;
        end
        core_wr_req  = c_req;
        core_wr_sel  = c_sel;
        core_wr_data = c_data;
        rd_sel_a     = r_a;
        rd_sel_b     = r_b;

        e.a = model_rf[r_a];
        e.b = model_rf[r_b];
        g = -1;
        if (!c_req) begin
            for (int k = 0; k < NU; k++) begin
                if (g < 0 && req[(model_ptr + k) % NU]) g = (model_ptr + k) % NU;
            end
        end
        e.ack = '0;
        if (g >= 0) e.ack[g] = 1'b1;
        exp_q.push_back(e);

        if (c_req) begin
            if (c_sel != 0) model_rf[c_sel] = c_data;
        end else if (g >= 0) begin
            if (g == 0) w = uq0.pop_front();
            else        w = uq1.pop_front();
            if (w.sel != 0) model_rf[w.sel] = w.data;
            model_ptr = (g + 1) % NU;
        end
    endtask

    // Monitor: compares what the DUT presents mid-cycle against the scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_ack", 32'(rf_wr_ack), 32'(e.ack));
                chk("sb_rd_a", rd_data_a, e.a);
                chk("sb_rd_b", rd_data_b, e.b);
            end
        end
    end

    // Asserts reset mid-cycle with unit 0 requesting a write to reg 9 that must never land.
    task automatic do_reset(bit live);
        @(negedge clk);
        core_wr_req = 1'b0;
        rf_wr_req   = 2'b01;
        rf_wr_sel[0 +: SW]  = SW'(9);
        rf_wr_data[0 +: DW] = 32'hDEAD_BEEF;
        #2;
        if (live) chk("ack_before_reset", 32'(rf_wr_ack), 32'd1);
        #1 rst = 1'b0;
        #1 chk("ack_async_reset", 32'(rf_wr_ack), 32'd0);
        repeat (2) begin
            @(negedge clk);
            rf_wr_req = '1;
            #4 chk("ack_in_reset", 32'(rf_wr_ack), 32'd0);
        end
        rf_wr_req = '0;
        model_clear();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic sweep_reads();
        c_req = 1'b0;
        for (int i = 0; i < NR / 2; i++) begin
            r_a = SW'(2 * i);
            r_b = SW'(2 * i + 1);
            step();
        end
    endtask

    initial begin
        rst = 1'b0;
        rd_sel_a = '0; rd_sel_b = '0;
        core_wr_req = 1'b0; core_wr_sel = '0; core_wr_data = '0;
        rf_wr_req = '0; rf_wr_sel = '0; rf_wr_data = '0;
        c_sel = '0; c_data = '0; r_a = '0; r_b = '0;
        model_clear();
        do_reset(1'b0);
        sweep_reads();

        // Divider-style pair on unit 0.
        push_wr(0, 3, 32'd81);
        push_wr(0, 7, 32'd37);
        r_a = 5'd3; r_b = 5'd7;
        step(); #3 chk("pair_ack_first", 32'(rf_wr_ack), 32'd1);
        step(); #3 chk("pair_ack_second", 32'(rf_wr_ack), 32'd1);
        step(); #3;
        chk("pair_rd_a_reg3", rd_data_a, 32'd81);
        chk("pair_rd_b_reg7", rd_data_b, 32'd37);

        // Core priority on the same index.
        push_wr(0, 5, 32'd99);
        c_req = 1'b1; c_sel = 5'd5; c_data = 32'd11; r_a = 5'd5;
        repeat (3) begin
            step(); #3 chk("core_blocks_ack", 32'(rf_wr_ack), 32'd0);
        end
        c_req = 1'b0;
        step(); #3 chk("unit_after_core_ack", 32'(rf_wr_ack), 32'd1);
        chk("reg5_core_value", rd_data_a, 32'd11);
        step(); #3 chk("reg5_final", rd_data_a, 32'd99);

        // Round-robin alternation from a freshly reset pointer, mid-cycle reset with req held.
        do_reset(1'b1);
        sweep_reads();
        for (int k = 0; k < 3; k++) begin
            push_wr(0, 10 + k, 32'(100 + k));
            push_wr(1, 20 + k, 32'(200 + k));
        end
        for (int k = 0; k < 6; k++) begin
            step(); #3 chk("rr_alternate", 32'(rf_wr_ack), (k % 2 == 0) ? 32'd1 : 32'd2);
        end
        for (int k = 0; k < 3; k++) push_wr(1, 24 + k, 32'(300 + k));
        for (int k = 0; k < 3; k++) begin
            step(); #3 chk("rr_unit1_alone", 32'(rf_wr_ack), 32'd2);
        end

        // Write to x0 is acked but stores nothing.
        push_wr(1, 0, 32'hFFFF_FFFF);
        r_a = 5'd0; r_b = 5'd0;
        step(); #3 chk("x0_ack", 32'(rf_wr_ack), 32'd2);
        step(); #3 chk("x0_reads_zero", rd_data_a, 32'd0);

        // No write-through on the read ports.
        c_req = 1'b1; c_sel = 5'd2; c_data = 32'd42; r_a = 5'd2;
        step(); #3 chk("rd_old_during_write", rd_data_a, 32'd0);
        c_req = 1'b0;
        step(); #3 chk("rd_new_after_write", rd_data_a, 32'd42);

        // Randomized traffic with one reset in the middle.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1500) begin
                do_reset(1'b1);
                sweep_reads();
            end
            c_req  = ($urandom_range(3) == 0);
            c_sel  = SW'($urandom_range(NR - 1));
            c_data = $urandom;
            if (uq0.size() == 0 && $urandom_range(1) == 1)
                push_wr(0, $urandom_range(NR - 1), $urandom);
            if (uq1.size() == 0 && $urandom_range(1) == 1)
                push_wr(1, $urandom_range(NR - 1), $urandom);
            r_a = SW'($urandom_range(NR - 1));
            r_b = SW'($urandom_range(NR - 1));
            step();
        end

        @(negedge clk);
        #4 chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
